// File: rtl/mips_mem_pkg.sv
// Shared encodings, buffer entry layout and default sizes for the data-memory stage.
// Used by dmem_wbuf and dmem_store_buf.
package mips_mem_pkg;

    localparam int DEF_ADDR_WORDS = 1024;
    localparam int DEF_WBUF_DEPTH = 4;

    typedef enum logic [2:0] {
        RC_LW  = 3'b000,
        RC_LB  = 3'b001,
        RC_LBU = 3'b010,
        RC_LH  = 3'b011,
        RC_LHU = 3'b100
    } readcontrol_e;

    typedef enum logic [1:0] {
        WC_SW   = 2'b00,
        WC_SH   = 2'b01,
        WC_SB   = 2'b10,
        WC_NONE = 2'b11
    } writecontrol_e;

    // The index is kept at full word-address width.
    // The top level zeroes the bits above the RAM depth, so entries compare like RAM words.
    typedef struct packed {
        logic [29:0] index;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] wc, input logic [1:0] offset);
        case (wc)
            WC_SW:   return 4'b1111;
            WC_SH:   return offset[1] ? 4'b1100 : 4'b0011;
            WC_SB:   return 4'b0001 << offset;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_wbuf_if.sv
// Core-to-data-memory bus.
// master is the core side, slave is the dmem_wbuf side.
interface dmem_wbuf_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [2:0]  readcontrol;
    logic [1:0]  writecontrol;
    logic [31:0] readdata;
    logic        stall;
    logic        wbuf_busy;

    modport master (
        output memread, memwrite, addr, writedata, readcontrol, writecontrol,
        input  readdata, stall, wbuf_busy
    );

    modport slave (
        input  memread, memwrite, addr, writedata, readcontrol, writecontrol,
        output readdata, stall, wbuf_busy
    );
endinterface

// File: rtl/dmem_store_buf.sv
// Circular FIFO of posted stores.
// Entries are presented oldest-first (slot 0 = head) with per-entry valid and index-match flags.
module dmem_store_buf
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = DEF_WBUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  entry_t                  push_entry,
    input  logic                    pop,
    input  logic [29:0]             lookup,
    output entry_t [DEPTH-1:0]      ordered,
    output logic   [DEPTH-1:0]      valid,
    output logic   [DEPTH-1:0]      match,
    output logic                    full,
    output logic                    empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    entry_t        mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, push and pop in one cycle share a slot.
    // The head is consumed combinationally before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ordered[i] = mem[rd_ptr + PW'(i)];
            valid[i]   = CW'(i) < count;
            match[i]   = valid[i] && (ordered[i].index == lookup);
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory stage: a posted write buffer drains into a word RAM, and loads are answered combinationally.
// Define DMEM_WBUF_FWD_EN to merge buffered stores into loads; otherwise a matching load stalls until drained.
module dmem_wbuf
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WORDS = DEF_ADDR_WORDS,
    parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
    input logic        clk,
    input logic        reset,
    dmem_wbuf_if.slave bus
);
    localparam int IW = $clog2(ADDR_WORDS);

    logic [31:0]                ram [ADDR_WORDS];
    logic [IW-1:0]              word_addr;
    logic [29:0]                index;
    logic [31:0]                lane_data;
    entry_t                     push_entry;
    entry_t [WBUF_DEPTH-1:0]    ordered;
    entry_t                     head;
    logic   [WBUF_DEPTH-1:0]    valid;
    logic   [WBUF_DEPTH-1:0]    match;
    logic                       full, empty;
    logic                       push, drain;
    logic                       load_stall, store_stall, stall_int;
    logic [31:0]                merged, load_data;
    logic [7:0]                 byte_sel;
    logic [15:0]                half_sel;
    logic                       unused_bits;

    assign word_addr = bus.addr[IW+1:2];
    assign index     = 30'(word_addr);
    assign head      = ordered[0];

    always_comb begin
        case (bus.writecontrol)
            WC_SH:   lane_data = {2{bus.writedata[15:0]}};
            WC_SB:   lane_data = {4{bus.writedata[7:0]}};
            default: lane_data = bus.writedata;
        endcase
    end

    assign push_entry = '{index: index, data: lane_data,
                          mask: lane_mask(bus.writecontrol, bus.addr[1:0])};

    dmem_store_buf #(.DEPTH(WBUF_DEPTH)) u_store_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .lookup     (index),
        .ordered    (ordered),
        .valid      (valid),
        .match      (match),
        .full       (full),
        .empty      (empty)
    );

    // Slot order is oldest-first, so later slots overwrite earlier ones per byte.
    always_comb begin
        merged     = ram[word_addr];
        load_stall = 1'b0;
`ifdef DMEM_WBUF_FWD_EN
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (match[i] && ordered[i].mask[b]) merged[8*b +: 8] = ordered[i].data[8*b +: 8];
            end
        end
`else
        load_stall = bus.memread && (|match);
`endif
    end

    // A store stall only counts as a stall when no drain occurs this cycle.
    // Drain is therefore computed from the load stall alone, which keeps the path acyclic.
    assign drain       = !empty && (!bus.memread || load_stall);
    assign store_stall = bus.memwrite && full && !drain;
    assign stall_int   = load_stall || store_stall;
    assign push        = bus.memwrite && !stall_int;

    always_ff @(posedge clk) begin
        if (reset && drain) begin
            for (int b = 0; b < 4; b++) begin
                if (head.mask[b]) ram[head.index[IW-1:0]][8*b +: 8] <= head.data[8*b +: 8];
            end
        end
    end

    assign byte_sel = merged[8*bus.addr[1:0] +: 8];
    assign half_sel = bus.addr[1] ? merged[31:16] : merged[15:0];

    always_comb begin
        case (readcontrol_e'(bus.readcontrol))
            RC_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            RC_LBU:  load_data = {24'h0, byte_sel};
            RC_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            RC_LHU:  load_data = {16'h0, half_sel};
            default: load_data = merged;
        endcase
    end

    assign bus.readdata  = reset ? load_data : 32'h0;
    assign bus.stall     = reset && stall_int;
    assign bus.wbuf_busy = reset && !empty;

    assign unused_bits = ^{bus.addr[31:IW+2], head.index[29:IW], valid};

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: reset, sub-word load/store, youngest-wins, full-buffer and reset-discard cases.
// The expected stall behaviour follows DMEM_WBUF_FWD_EN.
module tb_dmem_wbuf;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dmem_wbuf_if bus();

    dmem_wbuf #(.ADDR_WORDS(1024), .WBUF_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] wc, input logic rd);
        int n;
        bus.addr         = a;
        bus.writedata    = d;
        bus.writecontrol = wc;
        bus.readcontrol  = 3'b000;
        bus.memwrite     = 1'b1;
        bus.memread      = rd;
        n = 0;
        @(negedge clk);
        while (bus.stall && n < 16) begin
            n++;
            @(negedge clk);
        end
        if (bus.stall) chk("store_timeout", {31'h0, bus.stall}, 32'h0);
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        bus.memread  = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] rc,
                           output logic [31:0] data, output int stalls);
        bus.addr        = a;
        bus.readcontrol = rc;
        bus.memwrite    = 1'b0;
        bus.memread     = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (bus.stall && stalls < 16) begin
            stalls++;
            @(negedge clk);
        end
        if (bus.stall) chk("load_timeout", {31'h0, bus.stall}, 32'h0);
        data = bus.readdata;
        @(posedge clk);
        #1;
        bus.memread = 1'b0;
    endtask

    logic [31:0] rdata;
    int          nstall;
    int          cyc;

    initial begin
        reset            = 1'b0;
        bus.memread      = 1'b0;
        bus.memwrite     = 1'b0;
        bus.addr         = 32'h0;
        bus.writedata    = 32'h0;
        bus.readcontrol  = 3'b000;
        bus.writecontrol = 2'b11;

        repeat (2) @(negedge clk);
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_busy", {31'h0, bus.wbuf_busy}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        do_store(32'h40, 32'h11223344, 2'b00, 1'b0);
        do_load(32'h40, 3'b000, rdata, nstall);
        chk("lw_after_sw", rdata, 32'h11223344);
`ifdef DMEM_WBUF_FWD_EN
        chk("lw_fwd_stall", 32'(nstall), 32'h0);
`else
        chk("lw_nofwd_stall", 32'(nstall != 0), 32'h1);
`endif

        do_store(32'h41, 32'h000000AB, 2'b10, 1'b0);
        do_load(32'h41, 3'b001, rdata, nstall);
        chk("lb_41", rdata, 32'hFFFFFFAB);
        do_load(32'h41, 3'b010, rdata, nstall);
        chk("lbu_41", rdata, 32'h000000AB);
        do_load(32'h40, 3'b000, rdata, nstall);
        chk("lw_after_sb", rdata, 32'h1122AB44);

        do_store(32'h42, 32'h00008001, 2'b01, 1'b0);
        do_load(32'h42, 3'b011, rdata, nstall);
        chk("lh_42", rdata, 32'hFFFF8001);
        do_load(32'h42, 3'b100, rdata, nstall);
        chk("lhu_42", rdata, 32'h00008001);
        do_load(32'h43, 3'b001, rdata, nstall);
        chk("lb_43", rdata, 32'hFFFFFF80);

        do_store(32'h40, 32'h00000001, 2'b10, 1'b1);
        do_store(32'h40, 32'h00000002, 2'b10, 1'b1);
        do_load(32'h40, 3'b000, rdata, nstall);
        chk("young_before", rdata, 32'h8001AB02);
        do_load(32'h40, 3'b001, rdata, nstall);
        chk("lb_40_pos", rdata, 32'h00000002);
        idle(6);
        do_load(32'h40, 3'b000, rdata, nstall);
        chk("young_after", rdata, 32'h8001AB02);

        idle(4);
        for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(4*i), 32'hA0000000 + 32'(i), 2'b00, 1'b1);
        chk("full_busy", {31'h0, bus.wbuf_busy}, 32'h1);
        bus.addr         = 32'h110;
        bus.writedata    = 32'hA0000004;
        bus.writecontrol = 2'b00;
        bus.readcontrol  = 3'b000;
        bus.memwrite     = 1'b1;
        bus.memread      = 1'b1;
        @(negedge clk);
        chk("full_store_stall", {31'h0, bus.stall}, 32'h1);
        bus.memread = 1'b0;
        #1;
        chk("full_drain_nostall", {31'h0, bus.stall}, 32'h0);
        @(posedge clk);
        #1;
        bus.addr      = 32'h114;
        bus.writedata = 32'hA0000005;
        bus.memread   = 1'b1;
        @(negedge clk);
        chk("still_full", {31'h0, bus.stall}, 32'h1);
        bus.memwrite = 1'b0;
        bus.memread  = 1'b0;
        cyc = 0;
        while (bus.wbuf_busy && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("drain_cycles", 32'(cyc), 32'h4);
        do_load(32'h100, 3'b000, rdata, nstall);
        chk("rb_100", rdata, 32'hA0000000);
        do_load(32'h10F, 3'b000, rdata, nstall);
        chk("rb_10f_unaligned", rdata, 32'hA0000003);
        do_load(32'h110, 3'b111, rdata, nstall);
        chk("rb_110_rc7", rdata, 32'hA0000004);

        do_store(32'h80, 32'hCAFEF00D, 2'b00, 1'b0);
        idle(3);
        for (int i = 0; i < 3; i++) do_store(32'h80 + 32'(4*i), 32'hDEAD0000 + 32'(i), 2'b00, 1'b1);
        chk("pre_rst_busy", {31'h0, bus.wbuf_busy}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, bus.wbuf_busy}, 32'h0);
        chk("mid_rst_stall", {31'h0, bus.stall}, 32'h0);
        bus.addr        = 32'h80;
        bus.readcontrol = 3'b000;
        bus.memread     = 1'b1;
        #1;
        chk("mid_rst_readdata", bus.readdata, 32'h0);
        bus.memread = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("post_rst_busy", {31'h0, bus.wbuf_busy}, 32'h0);
        do_load(32'h80, 3'b000, rdata, nstall);
        chk("rst_discard", rdata, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d exp %0d", checks, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_wbuf.md
# dmem_wbuf

Data-memory stage downstream of the single-cycle `mips` core. It consumes the core's `aluout`, `writedata`, `memwrite`, `readcontrol` and `writecontrol` signals and returns `readdata`. Stores are posted into a small write buffer that drains into a single-ported word RAM in cycles where the RAM is not serving a load. Loads are answered combinationally in the same cycle, with sub-word extraction and sign/zero extension. A `stall` output freezes the core's PC when a load cannot be satisfied yet.

## Interface
Parameters:
- `ADDR_WORDS`, 1024: RAM depth in 32-bit words (power of two). Word index is `addr[log2(ADDR_WORDS)+1:2]`.
- `WBUF_DEPTH`, 4: write-buffer entries (power of two, at least 2).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `memread`, in, 1: current instruction is a load (core drives it from `memtoreg`).
- `memwrite`, in, 1: current instruction is a store.
- `addr`, in, 32: byte address, taken from `aluout`.
- `writedata`, in, 32: store data, right-aligned.
- `readcontrol`, in, 3: load type.
- `writecontrol`, in, 2: store size.
- `readdata`, out, 32: extended load result.
- `stall`, out, 1: hold the PC and suppress register write this cycle.
- `wbuf_busy`, out, 1: write buffer is non-empty.

## Operation
Encodings:
- `readcontrol`: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu. Any other value is treated as lw.
- `writecontrol`: 00 sw, 01 sh, 10 sb, 11 no-op store.

Alignment:
- Address bits below the access size are ignored, never trapped.
- Halfword lane is selected by `addr[1]`. Byte lane is selected by `addr[1:0]`.
- Lanes are little-endian: byte 0 is `[7:0]`.

Store push:
- At the clock edge when `memwrite=1` and `stall=0`, push one entry.
- Entry contents: {word index, `writedata` replicated into the lane, 4-bit byte mask}.

Drain:
- Condition: buffer non-empty and (`memread=0` or `stall=1`).
- Action: write the head entry into RAM under its byte mask, then pop.

Simultaneous push and pop:
- Allowed; occupancy is unchanged.
- When full, a drain in the same cycle frees the slot, so the store proceeds without stall.

Store stall:
- `stall=1` for a store only if the buffer is full and no drain occurs this cycle.

Load path:
- The combinational result is the RAM word merged byte-wise with every matching buffer entry, youngest entry winning per byte.
- The addressed lane is then extracted and extended.

Reset (`reset=0`):
- Buffer is emptied and pending stores are discarded; pointers and count return to 0.
- RAM contents are not reset.
- `readdata=0`, `stall=0`, `wbuf_busy=0` while reset is asserted.
- Reset mid-drain: the RAM write at that edge does not occur.

## Timing
- Load latency: 0 cycles. `readdata` is valid in the same cycle as `addr`.
- A store is visible to a load issued the next cycle (forwarding on), or after its drain (forwarding off).
- Drain throughput: 1 entry per cycle.
- `stall` is combinational from the current inputs plus registered buffer state.
- Once stall conditions clear, `stall` falls within `WBUF_DEPTH` cycles.

## Configuration
`DMEM_WBUF_FWD_EN`:
- Defined: store-to-load forwarding merge as described in Operation; loads never stall.
- Undefined: no merge logic. A load whose word index matches any valid entry asserts `stall` until no match remains. Drains continue during the stall (drain condition includes `stall=1`), so no deadlock occurs.

## Structure
- Package `mips_mem_pkg`: readcontrol and writecontrol encodings, the entry struct {index, data, mask}, and default depth constants.
- Sub-module `dmem_store_buf`: circular FIFO with push/pop, full/empty and per-entry match outputs.
- Top level contains: RAM array, lane/mask generation, merge, extension and stall logic.

## Test plan
- Reset, then sw 0x11223344 to 0x40, then lw 0x40 next cycle: readdata=0x11223344 and stall=0. With forwarding off: one or more stall cycles, then 0x11223344.
- sb 0xAB to 0x41, then lb 0x41: 0xFFFFFFAB; lbu 0x41: 0x000000AB; lh 0x42 after sh 0x8001 to 0x42: 0xFFFF8001.
- Two stores to the same word (sb 0x40=0x01, sb 0x40=0x02) back-to-back, then lw: byte 0 reads 0x02 (youngest wins), before and after drain.
- Back-to-back loads keep the buffer full with 4 entries; then a 5th store with memwrite=1, memread=0: drain and push occur together, stall=0, count stays 4.
- Buffer holds 3 entries; drop reset mid-stream: wbuf_busy=0 on the next edge, and a later lw returns the old RAM value.
